// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: frame width, default bit period
// and the receiver FSM state encodings.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int DEFAULT_PERIOD = 1250;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Byte stream from the UART receiver to its consumer (valid/ready, first-word
// fall-through data).
interface uart_byte_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_byte_fifo.sv
// Small first-word fall-through byte FIFO; a push while full is still taken
// when a pop frees the head slot in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Storage is cleared on reset so the head reads 0x00 until the first push.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling FSM with glitch and
// framing checks, feeding a byte FIFO presented as a valid/ready stream.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PERIOD,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  uart_byte_rx_if.master   m,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int IW = $clog2(DATA_BITS);

  logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push, pop, full, empty, expired;

  assign rx_meta_d = rx;
  assign rxs_d     = rx_meta_q;
  assign expired   = (cnt_q == CW'(1));

  // The stop bit is sampled mid-bit and the FSM goes straight back to IDLE,
  // leaving half a bit of margin to catch the next start edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          cnt_d   = CW'(PERIOD / 2);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CW'(PERIOD);
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = CW'(PERIOD);
          if (idx_q == IW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs_q) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop       = !empty && m.m_ready;
  assign overrun_d = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shift_q),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (m.m_data)
  );

  assign m.m_valid = !empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed testbench for uart_byte_rx: frames are driven bit by bit, expected
// bytes go into a scoreboard queue and a monitor checks them on delivery.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int P     = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic frame_err, overrun, busy;

  exp_t expq[$];
  int   checks      = 0;
  int   failures    = 0;
  int   edge_cnt    = 0;
  int   ferr_cycles = 0;
  int   ovr_cycles  = 0;
  int   busy_low    = 0;
  int   ferr0, ovr0;

  uart_byte_rx_if bus ();

  uart_byte_rx #(
    .PERIOD (P),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m         (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic holdBit(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
  endtask

  // Changes m_ready just after a rising edge so the monitor's negedge view
  // always matches what the DUT samples at the following edge.
  task automatic setReady(input logic v);
    @(posedge clk);
    #1 bus.m_ready = v;
    @(negedge clk);
  endtask

  // Called at a negedge; the next rising edge is cycle 0 of the frame.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                               input bit expect_byte, input bit timed);
    int c0;
    exp_t e;
    c0 = edge_cnt + 1;
    if (expect_byte) begin
      e.data = b;
      e.due  = timed ? (c0 + 2 + P / 2 + 9 * P) : -1;
      expq.push_back(e);
    end
    rx = 1'b0;
    holdBit(P);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      holdBit(P);
    end
    rx = stop_bit;
    holdBit(P);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_err) ferr_cycles++;
      if (overrun)   ovr_cycles++;
      if (bus.m_valid && bus.m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, required no byte", bus.m_data);
        end else begin
          e = expq.pop_front();
          checkOutput("byte_data", int'(bus.m_data), int'(e.data));
          if (e.due >= 0) checkOutput("byte_time", edge_cnt, e.due);
        end
      end
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    waitCycles(3);
    rst = 1'b0;

    checkOutput("reset_m_valid",   int'(bus.m_valid), 0);
    checkOutput("reset_m_data",    int'(bus.m_data),  0);
    checkOutput("reset_frame_err", int'(frame_err),   0);
    checkOutput("reset_overrun",   int'(overrun),     0);
    checkOutput("reset_busy",      int'(busy),        0);
    waitCycles(2);

    $display("[TB] single byte");
    applyStimulus(8'h31, 1'b1, 1'b1, 1'b1);
    waitCycles(P);
    checkOutput("single_drained", expq.size(), 0);
    checkOutput("single_ferr", ferr_cycles, 0);
    checkOutput("single_ovr",  ovr_cycles,  0);

    $display("[TB] back-to-back");
    busy_low = 0;
    for (int k = 0; k < 5; k++) applyStimulus(8'h31 + 8'(k), 1'b1, 1'b1, 1'b1);
    checkOutput("b2b_busy_low_cycles", busy_low, 5 * P / 2);
    waitCycles(P);
    checkOutput("b2b_drained", expq.size(), 0);
    checkOutput("b2b_ovr", ovr_cycles, 0);

    $display("[TB] glitch");
    rx = 1'b0;
    waitCycles(P / 2 - 2);
    checkOutput("glitch_busy_during", int'(busy), 1);
    rx = 1'b1;
    waitCycles(2 * P);
    checkOutput("glitch_busy_after", int'(busy), 0);
    checkOutput("glitch_ferr", ferr_cycles, 0);

    $display("[TB] framing error");
    ferr0 = ferr_cycles;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    waitCycles(2 * P);
    checkOutput("ferr_busy_break", int'(busy), 1);
    checkOutput("ferr_no_valid", int'(bus.m_valid), 0);
    rx = 1'b1;
    waitCycles(4);
    checkOutput("ferr_busy_released", int'(busy), 0);
    checkOutput("ferr_pulse_cycles", ferr_cycles - ferr0, 1);

    $display("[TB] overrun");
    setReady(1'b0);
    ovr0 = ovr_cycles;
    for (int k = 0; k < 4; k++) applyStimulus(8'h41 + 8'(k), 1'b1, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("ovr_before_fifth", ovr_cycles - ovr0, 0);
    applyStimulus(8'h45, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("ovr_pulse_cycles", ovr_cycles - ovr0, 1);
    checkOutput("ovr_head_held", int'(bus.m_data), 'h41);
    setReady(1'b1);
    waitCycles(8);
    checkOutput("ovr_drained", expq.size(), 0);
    checkOutput("ovr_valid_low", int'(bus.m_valid), 0);

    $display("[TB] reset mid-frame");
    setReady(1'b0);
    applyStimulus(8'h77, 1'b1, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("rst_pre_valid", int'(bus.m_valid), 1);
    rx = 1'b0;
    waitCycles(P);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      waitCycles(i == 3 ? P / 2 : P);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_m_valid",   int'(bus.m_valid), 0);
    checkOutput("rst_m_data",    int'(bus.m_data),  0);
    checkOutput("rst_busy",      int'(busy),        0);
    checkOutput("rst_frame_err", int'(frame_err),   0);
    checkOutput("rst_overrun",   int'(overrun),     0);
    rx = 1'b1;
    ferr0 = ferr_cycles;
    ovr0  = ovr_cycles;
    setReady(1'b1);
    waitCycles(2 * P);
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
    waitCycles(P);
    checkOutput("rst_after_ferr", ferr_cycles - ferr0, 0);
    checkOutput("rst_after_ovr",  ovr_cycles - ovr0,   0);

    checkOutput("final_queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
